pipeline_controller: RTL and testbench

Run/halt sequencer and hazard unit that drives the control side of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 16-bit five-stage CPU. It turns the front-panel `exec` button and the decoded HALT instruction into a clean start, run, drain and halt sequence. It detects load-use and taken-branch hazards and produces the per-register `enable`/`stall`/`flush` and PC-write strobes. It also keeps stall and flush event counters for the debug display.

---
 rtl/pipeline_controller_if.sv | 35 +++
 rtl/pipeline_controller.sv | 115 +++++++++++
 tb/tb_pipeline_controller.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_controller_if.sv
// Control-side bundle between the hazard/sequencer unit and the rest of the CPU:
// run button, decode/execute hazard inputs, pipeline register strobes and debug counters.
interface pipeline_controller_if;
    logic        exec;
    logic        id_is_halt;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [2:0]  ex_rd;
    logic        ex_branch_taken;
    logic        pipe_enable;
    logic        pc_write;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        idex_flush;
    logic        is_halt_now;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    modport master (
        output exec, id_is_halt, id_rs, id_rt, id_uses_rs, id_uses_rt,
               ex_mem_read, ex_rd, ex_branch_taken,
        input  pipe_enable, pc_write, ifid_stall, ifid_flush, idex_flush,
               is_halt_now, stall_count, flush_count
    );

    modport slave (
        input  exec, id_is_halt, id_rs, id_rt, id_uses_rs, id_uses_rt,
               ex_mem_read, ex_rd, ex_branch_taken,
        output pipe_enable, pc_write, ifid_stall, ifid_flush, idex_flush,
               is_halt_now, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_controller.sv
// Run/halt sequencer and hazard unit for the five-stage pipeline: start/run/drain/halt
// sequencing, load-use and taken-branch handling, and stall/flush event counters.
module pipeline_controller (
    input  logic                 clock,
    input  logic                 reset_n,
    pipeline_controller_if.slave bus
);
    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        exec_q;
    logic [2:0]  drain_q, drain_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    logic exec_rise;
    logic load_use;
    logic pipe_enable, pc_write, ifid_stall, ifid_flush, idex_flush, is_halt_now;

    assign exec_rise = bus.exec & ~exec_q;

    // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = bus.ex_mem_read && (bus.ex_rd != 3'd0) &&
                      (((bus.ex_rd == bus.id_rs) && bus.id_uses_rs) ||
                       ((bus.ex_rd == bus.id_rt) && bus.id_uses_rt));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_HALT;
            exec_q        <= 1'b0;
            drain_q       <= 3'd0;
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            exec_q        <= bus.exec;
            drain_q       <= drain_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        pipe_enable   = 1'b0;
        pc_write      = 1'b0;
        ifid_stall    = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        is_halt_now   = 1'b0;

        case (state_q)
            ST_HALT: begin
                is_halt_now = 1'b1;
                if (exec_rise) begin
                    state_d       = ST_RUN;
                    stall_count_d = 16'd0;
                    flush_count_d = 16'd0;
                end
            end

            ST_RUN: begin
                pipe_enable = 1'b1;
                // A taken branch squashes the ID instruction, so its hazards and HALT are moot.
                if (bus.ex_branch_taken) begin
                    ifid_flush    = 1'b1;
                    idex_flush    = 1'b1;
                    pc_write      = 1'b1;
                    flush_count_d = flush_count_q + 16'd1;
                end else if (load_use) begin
                    ifid_stall    = 1'b1;
                    idex_flush    = 1'b1;
                    stall_count_d = stall_count_q + 16'd1;
                end else begin
                    pc_write = 1'b1;
                end
                if ((bus.id_is_halt && !bus.ex_branch_taken) || exec_rise) begin
                    state_d = ST_DRAIN;
                    drain_d = 3'd4;
                end
            end

            ST_DRAIN: begin
                pipe_enable = 1'b1;
                ifid_flush  = 1'b1;
                drain_d     = drain_q - 3'd1;
                if (drain_q <= 3'd1) begin
                    state_d = ST_HALT;
                    drain_d = 3'd0;
                end
            end

            default: begin
                state_d = ST_HALT;
                drain_d = 3'd0;
            end
        endcase
    end

    assign bus.pipe_enable = pipe_enable;
    assign bus.pc_write    = pc_write;
    assign bus.ifid_stall  = ifid_stall;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.is_halt_now = is_halt_now;
    assign bus.stall_count = stall_count_q;
    assign bus.flush_count = flush_count_q;
endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: directed scenarios plus randomized traffic, each cycle
// compared against a behavioural model of the run/drain/halt rules.
module tb_pipeline_controller;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    pipeline_controller_if bus ();

    pipeline_controller dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: running flag, drain cycles left, plain integer counters.
    bit m_running;
    int m_drain_left;
    int m_stalls;
    int m_flushes;
    bit m_exec_prev;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_running    = 1'b0;
        m_drain_left = 0;
        m_stalls     = 0;
        m_flushes    = 0;
        m_exec_prev  = 1'b0;
    endfunction

    function automatic bit model_lu();
        return bus.ex_mem_read && bus.ex_rd != 0 &&
               ((bus.ex_rd == bus.id_rs && bus.id_uses_rs) ||
                (bus.ex_rd == bus.id_rt && bus.id_uses_rt));
    endfunction

    // {is_halt_now, pipe_enable, pc_write, ifid_stall, ifid_flush, idex_flush}
    function automatic logic [5:0] model_outs();
        if (m_drain_left > 0)       return 6'b010010;
        if (!m_running)             return 6'b100000;
        if (bus.ex_branch_taken)    return 6'b011011;
        if (model_lu())             return 6'b010101;
        return 6'b011000;
    endfunction

    function automatic void model_edge();
        bit rise;
        rise = bus.exec && !m_exec_prev;
        if (m_drain_left > 0) begin
            m_drain_left--;
        end else if (m_running) begin
            if (bus.ex_branch_taken)  m_flushes = (m_flushes + 1) % 65536;
            else if (model_lu())      m_stalls  = (m_stalls + 1) % 65536;
            if ((bus.id_is_halt && !bus.ex_branch_taken) || rise) begin
                m_running    = 1'b0;
                m_drain_left = 4;
            end
        end else if (rise) begin
            m_running = 1'b1;
            m_stalls  = 0;
            m_flushes = 0;
        end
        m_exec_prev = bus.exec;
    endfunction

    task automatic drive(input bit ex, input bit hlt, input logic [2:0] rs, input logic [2:0] rt,
                         input bit urs, input bit urt, input bit mr, input logic [2:0] rd,
                         input bit br);
        bus.exec            = ex;
        bus.id_is_halt      = hlt;
        bus.id_rs           = rs;
        bus.id_rt           = rt;
        bus.id_uses_rs      = urs;
        bus.id_uses_rt      = urt;
        bus.ex_mem_read     = mr;
        bus.ex_rd           = rd;
        bus.ex_branch_taken = br;
    endtask

    task automatic check_state(input string tag);
        logic [5:0] got;
        got = {bus.is_halt_now, bus.pipe_enable, bus.pc_write,
               bus.ifid_stall, bus.ifid_flush, bus.idex_flush};
        check_val({tag, "_outs"}, {26'd0, got}, {26'd0, model_outs()});
        check_val({tag, "_counts"}, {bus.stall_count, bus.flush_count},
                  {m_stalls[15:0], m_flushes[15:0]});
    endtask

    // Inputs are already driven (just after a falling edge); check, then clock once.
    task automatic tick(input string tag);
        #2;
        check_state(tag);
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic exec_pulse(input string tag);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick({tag, "_rise"});
        idle();
        tick({tag, "_after"});
    endtask

    task automatic wait_halted(input string tag);
        int n;
        n = 0;
        idle();
        while ((m_running || m_drain_left > 0) && n < 10) begin
            if (m_running) bus.id_is_halt = 1'b1;
            tick(tag);
            idle();
            n++;
        end
        check_val({tag, "_halt_reached"}, {31'd0, bus.is_halt_now}, 32'd1);
    endtask

    initial begin
        model_reset();
        idle();
        @(negedge clock);
        #2;
        check_state("reset");
        @(negedge clock);
        reset_n = 1'b1;

        tick("halt_idle0");
        tick("halt_idle1");

        // Start: HALT -> RUN one edge after the exec rise.
        exec_pulse("start");
        check_val("start_running", {31'd0, bus.is_halt_now}, 32'd0);

        drive(0, 0, 3'd3, 3'd0, 1, 0, 1, 3'd3, 0);
        tick("loaduse");
        idle();
        tick("after_lu");
        drive(0, 0, 3'd0, 3'd0, 1, 0, 1, 3'd0, 0);
        tick("lu_rd0");
        drive(0, 0, 3'd1, 3'd5, 0, 1, 1, 3'd5, 0);
        tick("loaduse_rt");
        drive(0, 0, 3'd5, 3'd2, 0, 1, 1, 3'd5, 0);
        tick("lu_rs_unused");

        drive(0, 1, 3'd4, 3'd0, 1, 0, 1, 3'd4, 1);
        tick("br_prio");
        idle();
        tick("br_after");
        check_val("br_no_drain", {31'd0, bus.ifid_flush}, 32'd0);

        bus.id_is_halt = 1'b1;
        tick("halt_instr");
        idle();
        for (int i = 0; i < 4; i++) tick("drain");
        tick("halted");
        tick("halted_hold");

        exec_pulse("restart");

        // 65537 consecutive stall cycles wrap the counter back to 1.
        drive(0, 0, 3'd2, 3'd2, 1, 1, 1, 3'd2, 0);
        for (int i = 0; i < 65537; i++) tick("wrap_run");
        idle();
        #2;
        check_val("wrap", {16'd0, bus.stall_count}, 32'd1);
        tick("wrap_done");

        // exec rise together with HALT: one drain of four cycles.
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        tick("rise_halt");
        for (int i = 0; i < 4; i++) tick("rise_halt_drain");
        tick("rise_halt_held");
        idle();
        tick("rise_halt_low");
        exec_pulse("restart2");

        // exec rise together with a taken branch: flush counted and drain entered.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        tick("rise_br");
        idle();
        for (int i = 0; i < 4; i++) tick("rise_br_drain");
        tick("rise_br_halted");

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit ex;
            ex = ($urandom_range(0, 19) == 0) ? ~bus.exec : bus.exec;
            drive(ex, $urandom_range(0, 15) == 0, 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), $urandom_range(0, 5) == 0);
            tick("rand");
        end

        // Asynchronous reset in the middle of a drain.
        wait_halted("pre_reset");
        exec_pulse("reset_run");
        bus.id_is_halt = 1'b1;
        tick("reset_halt_instr");
        idle();
        tick("reset_drain");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_state("async_reset");
        check_val("async_reset_halt", {31'd0, bus.is_halt_now}, 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        tick("post_reset0");
        tick("post_reset1");
        exec_pulse("post_reset_start");
        check_val("post_reset_run", {31'd0, bus.pipe_enable}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
